// File: rtl/matrix_multiply_host_ctrl_if.sv
// Host-side bundle between the operand/result streams, the controller and the
// matrix_multiply_top RAM/start/busy port. master = controller, slave = environment.
interface matrix_multiply_host_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  done;
    logic                  mm_start;
    logic                  mm_busy;
    logic [ADDR_WIDTH-1:0] mm_ram_addr;
    logic                  mm_ram_wen;
    logic [1:0]            mm_ram_sel;
    logic [DATA_WIDTH-1:0] mm_ram_data_in;
    logic [DATA_WIDTH-1:0] mm_ram_data_out;

    modport master (
        input  s_valid, s_data, m_ready, mm_busy, mm_ram_data_out,
        output s_ready, m_valid, m_data, m_last, done,
               mm_start, mm_ram_addr, mm_ram_wen, mm_ram_sel, mm_ram_data_in
    );

    modport slave (
        output s_valid, s_data, m_ready, mm_busy, mm_ram_data_out,
        input  s_ready, m_valid, m_data, m_last, done,
               mm_start, mm_ram_addr, mm_ram_wen, mm_ram_sel, mm_ram_data_in
    );
endinterface

// File: rtl/matrix_multiply_host_ctrl.sv
// Streams operands into the matrix X/Y RAMs, kicks the multiply, waits on busy,
// then reads Z back out as a valid/ready stream with a last flag.
module matrix_multiply_host_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 2,
    parameter int Y_COLS        = 2,
    parameter int X_COLS_Y_ROWS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    matrix_multiply_host_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(X_ROWS * X_COLS_Y_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(X_COLS_Y_ROWS * Y_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] Z_LAST = ADDR_WIDTH'(X_ROWS * Y_COLS - 1);

    typedef enum logic [2:0] {
        LOAD_X, LOAD_Y, START, GUARD, WAIT, RD_ISSUE, RD_CAP, RD_OUT
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  wen_q;
    logic [1:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  start_q;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_last_q;
    logic                  done_q;

    assign bus.s_ready        = (state_q == LOAD_X || state_q == LOAD_Y) && !rst;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_data         = m_data_q;
    assign bus.m_last         = m_last_q;
    assign bus.done           = done_q;
    assign bus.mm_start       = start_q;
    assign bus.mm_ram_addr    = addr_q;
    assign bus.mm_ram_wen     = wen_q;
    assign bus.mm_ram_sel     = sel_q;
    assign bus.mm_ram_data_in = din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD_X;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            sel_q     <= 2'd0;
            addr_q    <= '0;
            din_q     <= '0;
            start_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            unique case (state_q)
                LOAD_X, LOAD_Y: begin
                    // s_ready is implied here, so s_valid alone marks an accepted beat
                    if (bus.s_valid) begin
                        wen_q  <= 1'b1;
                        sel_q  <= (state_q == LOAD_Y) ? 2'd1 : 2'd0;
                        addr_q <= cnt_q;
                        din_q  <= bus.s_data;
                        if (cnt_q == ((state_q == LOAD_X) ? X_LAST : Y_LAST)) begin
                            cnt_q   <= '0;
                            state_q <= (state_q == LOAD_X) ? LOAD_Y : START;
                        end else begin
                            cnt_q <= cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                START: begin
                    if (!bus.mm_busy) begin
                        start_q <= 1'b1;
                        state_q <= GUARD;
                    end
                end
                // busy may still be low the cycle after start; don't trust it yet
                GUARD: state_q <= WAIT;
                WAIT: begin
                    if (!bus.mm_busy) state_q <= RD_ISSUE;
                end
                RD_ISSUE: begin
                    sel_q   <= 2'd2;
                    addr_q  <= cnt_q;
                    state_q <= RD_CAP;
                end
                RD_CAP: begin
                    m_data_q  <= bus.mm_ram_data_out;
                    m_valid_q <= 1'b1;
                    m_last_q  <= (cnt_q == Z_LAST);
                    state_q   <= RD_OUT;
                end
                RD_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (m_last_q) begin
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= LOAD_X;
                        end else begin
                            cnt_q   <= cnt_q + ADDR_WIDTH'(1);
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                default: state_q <= LOAD_X;
            endcase
        end
    end
endmodule
